// File: rtl/vend_dispense_sched.sv
// Round-robin owner of one item motor and one coin ejector; request sampled in IDLE, grant next cycle.
// Requests hold level until done; others wait in req with no timeout, and a jam parks the block in FAULT.
module vend_dispense_sched #(
  parameter int N            = 4,
  parameter int MOTOR_CYC    = 8,
  parameter int DROP_TIMEOUT = 64,
  parameter int COIN_ON_CYC  = 4,
  parameter int COIN_GAP_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     req_out,
  input  logic [2*N-1:0]   req_chg,
  output logic [N-1:0]     grant,
  output logic [N-1:0]     done,
  output logic             motor_on,
  input  logic             drop_sense,
  output logic             coin_pulse,
  output logic             busy,
  output logic             fault
);

  localparam int MAX_A = (MOTOR_CYC > DROP_TIMEOUT) ? MOTOR_CYC : DROP_TIMEOUT;
  localparam int MAX_B = (COIN_ON_CYC > COIN_GAP_CYC) ? COIN_ON_CYC : COIN_GAP_CYC;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXP + 1);
  localparam int IW    = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE, S_MOTOR, S_WAIT_DROP, S_COIN_ON, S_COIN_GAP, S_DONE, S_FAULT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n, rr, rr_n;
  logic          out_l, out_n;
  logic [1:0]    coins, coins_n;
  logic          dropped, dropped_n;

  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic          win_out;
  logic [1:0]    win_chg;
  logic [1:0]    win_coins;
  int            j;

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_out = 1'b0;
    win_chg = 2'b00;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(rr) + i) % N;
      if (!win_vld && req[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
        win_out = req_out[j];
        win_chg = req_chg[2*j +: 2];
      end
    end
    win_coins = (win_chg == 2'b01) ? 2'd1 : (win_chg == 2'b10) ? 2'd2 : 2'd0;
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    rr_n      = rr;
    out_n     = out_l;
    coins_n   = coins;
    dropped_n = dropped;
    case (state)
      S_IDLE: begin
        if (win_vld) begin
          idx_n     = win_idx;
          out_n     = win_out;
          coins_n   = win_coins;
          dropped_n = 1'b0;
          rr_n      = (win_idx == IW'(N - 1)) ? IW'(0) : win_idx + 1'b1;
          if (win_out)               state_n = S_MOTOR;
          else if (win_coins != 2'd0) state_n = S_COIN_ON;
          else                        state_n = S_DONE;
        end
      end
      S_MOTOR: begin
        if (drop_sense) dropped_n = 1'b1;
        if (cnt == CW'(MOTOR_CYC - 1)) state_n = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        if (dropped || drop_sense)
          state_n = (coins != 2'd0) ? S_COIN_ON : S_DONE;
        else if (cnt == CW'(DROP_TIMEOUT - 1))
          state_n = S_FAULT;
      end
      S_COIN_ON: begin
        if (cnt == CW'(COIN_ON_CYC - 1)) state_n = S_COIN_GAP;
      end
      S_COIN_GAP: begin
        if (cnt == CW'(COIN_GAP_CYC - 1)) begin
          coins_n = coins - 2'd1;
          state_n = (coins > 2'd1) ? S_COIN_ON : S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_IDLE;
    endcase
    // Every state entry restarts the cycle count.
    cnt_n = (state_n != state) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      rr      <= '0;
      out_l   <= 1'b0;
      coins   <= 2'd0;
      dropped <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      rr      <= rr_n;
      out_l   <= out_n;
      coins   <= coins_n;
      dropped <= dropped_n;
    end
  end

  logic owner_vld;
  assign owner_vld  = (state != S_IDLE) && (state != S_FAULT);
  assign grant      = owner_vld ? (N'(1) << idx) : '0;
  assign done       = (state == S_DONE) ? (N'(1) << idx) : '0;
  assign motor_on   = (state == S_MOTOR);
  assign coin_pulse = (state == S_COIN_ON);
  assign busy       = (state != S_IDLE);
  assign fault      = (state == S_FAULT);

endmodule

// File: tb/tb_vend_dispense_sched.sv
// Directed bench for vend_dispense_sched: per-cycle output vectors against hand-derived phase tables.
module tb_vend_dispense_sched;
  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_out;
  logic [7:0] req_chg;
  logic [3:0] grant;
  logic [3:0] done;
  logic       motor_on;
  logic       drop_sense;
  logic       coin_pulse;
  logic       busy;
  logic       fault;

  int checks = 0;
  int errors = 0;

  vend_dispense_sched dut (
    .clk(clk), .rst(rst), .req(req), .req_out(req_out), .req_chg(req_chg),
    .grant(grant), .done(done), .motor_on(motor_on), .drop_sense(drop_sense),
    .coin_pulse(coin_pulse), .busy(busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {grant, done, motor_on, coin_pulse, busy, fault}
  function automatic logic [11:0] obs();
    return {grant, done, motor_on, coin_pulse, busy, fault};
  endfunction

  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (grant == 4'b0 && cyc < 200);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (done == 4'b0 && cyc < 200);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (busy && cyc < 200);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs() !== 12'h000) begin
      errors++;
      $display("FAIL reset_async got %h want %h", obs(), 12'h000);
    end
    @(negedge clk);
    checks++;
    if (obs() !== 12'h000) begin
      errors++;
      $display("FAIL reset_held got %h want %h", obs(), 12'h000);
    end
    rst = 1'b0;
  endtask

  // Requester 0: dispense + one coin, drop seen in motor cycle 3.
  task automatic test_dispense_coin();
    logic [11:0] exp;
    req = 4'b0001; req_out = 4'b0001; req_chg = 8'b0000_0001;
    @(posedge clk);
    for (int t = 1; t <= 19; t++) begin
      @(negedge clk);
      exp = {(t <= 18) ? 4'b0001 : 4'b0000, (t == 18) ? 4'b0001 : 4'b0000,
             t <= 8, (t >= 10 && t <= 13), t <= 18, 1'b0};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL dispense_coin cyc %0d got %h want %h", t, obs(), exp);
      end
      if (t == 3) drop_sense = 1'b1;
      if (t == 4) drop_sense = 1'b0;
      if (t == 18) req = 4'b0000;
    end
  endtask

  task automatic test_two_requesters();
    int cyc;
    drop_sense = 1'b1;
    req = 4'b1010; req_out = 4'b1010; req_chg = 8'h00;
    wait_grant(cyc);
    checks++;
    if (grant !== 4'b0010 || cyc != 1) begin
      errors++;
      $display("FAIL rr_first got %b/%0d want 0010/1", grant, cyc);
    end
    wait_done(cyc);
    checks++;
    if (done !== 4'b0010 || cyc != 9) begin
      errors++;
      $display("FAIL rr_first_done got %b/%0d want 0010/9", done, cyc);
    end
    req = 4'b1000;
    wait_grant(cyc);
    checks++;
    if (grant !== 4'b1000 || cyc != 2) begin
      errors++;
      $display("FAIL rr_second got %b/%0d want 1000/2", grant, cyc);
    end
    wait_done(cyc);
    checks++;
    if (done !== 4'b1000) begin
      errors++;
      $display("FAIL rr_second_done got %b want 1000", done);
    end
    req = 4'b0000; drop_sense = 1'b0;
    wait_idle(cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111; req_out = 4'b0000; req_chg = 8'h00;
    for (int s = 0; s < 5; s++) begin
      wait_grant(cyc);
      checks++;
      if ({grant, done} !== {seq[s], seq[s]}) begin
        errors++;
        $display("FAIL b2b_%0d got %b/%b want %b/%b", s, grant, done, seq[s], seq[s]);
      end
      if (s == 4) req = 4'b0000;
    end
    wait_idle(cyc);
  endtask

  // Requester 2: no item, two coins.
  task automatic test_two_coins();
    logic [11:0] exp;
    req = 4'b0100; req_out = 4'b0000; req_chg = 8'b0010_0000;
    @(posedge clk);
    for (int t = 1; t <= 18; t++) begin
      @(negedge clk);
      exp = {(t <= 17) ? 4'b0100 : 4'b0000, (t == 17) ? 4'b0100 : 4'b0000,
             1'b0, (t <= 4 || (t >= 9 && t <= 12)), t <= 17, 1'b0};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL two_coins cyc %0d got %h want %h", t, obs(), exp);
      end
      if (t == 17) req = 4'b0000;
    end
  endtask

  task automatic test_jam_fault();
    logic [11:0] exp;
    req = 4'b0001; req_out = 4'b0001; req_chg = 8'h00; drop_sense = 1'b0;
    @(posedge clk);
    for (int t = 1; t <= 85; t++) begin
      @(negedge clk);
      exp = {(t <= 72) ? 4'b0001 : 4'b0000, 4'b0000, t <= 8, 1'b0, 1'b1, t >= 73};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL jam cyc %0d got %h want %h", t, obs(), exp);
      end
      if (t == 72) req = 4'b0000;
      if (t == 75) begin req = 4'b1111; req_out = 4'b1111; end
    end
    req = 4'b0000; req_out = 4'b0000;
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 12'h000) begin
      errors++;
      $display("FAIL fault_clear got %h want %h", obs(), 12'h000);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0001; req_out = 4'b0001; req_chg = 8'h00;
    @(posedge clk);
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      checks++;
      if ({grant, motor_on} !== {4'b0001, 1'b1}) begin
        errors++;
        $display("FAIL mid_motor cyc %0d got %b/%b want 0001/1", t, grant, motor_on);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 12'h000) begin
      errors++;
      $display("FAIL mid_rst_async got %h want %h", obs(), 12'h000);
    end
    @(negedge clk);
    checks++;
    if (obs() !== 12'h000) begin
      errors++;
      $display("FAIL mid_rst_held got %h want %h", obs(), 12'h000);
    end
    rst = 1'b0;
    req = 4'b0011; req_out = 4'b0000;
    wait_grant(cyc);
    checks++;
    if ({grant, done} !== {4'b0001, 4'b0001} || cyc != 1) begin
      errors++;
      $display("FAIL rr_after_rst got %b/%b/%0d want 0001/0001/1", grant, done, cyc);
    end
    req = 4'b0010;
    wait_grant(cyc);
    checks++;
    if ({grant, done} !== {4'b0010, 4'b0010} || cyc != 2) begin
      errors++;
      $display("FAIL req1_after_rst got %b/%b/%0d want 0010/0010/2", grant, done, cyc);
    end
    req = 4'b0000;
    wait_idle(cyc);
    checks++;
    if (busy !== 1'b0 || cyc != 1) begin
      errors++;
      $display("FAIL final_idle got %b/%0d want 0/1", busy, cyc);
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; req_out = 4'b0; req_chg = 8'h00; drop_sense = 1'b0;
    test_reset();
    test_dispense_coin();
    test_two_requesters();
    test_back_to_back();
    test_two_coins();
    test_jam_fault();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
